// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and the MEM stage.
// MEM always wins a same-cycle tie. Only one bus transaction is outstanding at a time.
// A transaction that runs too long in ADDR+DATA is aborted and answered with zero data.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // Fetch side
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_kill_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  // MEM stage side
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_be_i,
  output logic        mem_rvalid_o,
  output logic [31:0] mem_rdata_o,
  output logic        stall_mem_o,
  // Shared bus
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_timeout_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  // The counter is only 8 bits wide, so a larger limit can never be reached.
  localparam bit         TimeoutEn  = (TIMEOUT_CYCLES <= 32'd255);
  localparam logic [7:0] TimeoutCnt = TimeoutEn ? 8'(TIMEOUT_CYCLES) : 8'hFF;

  state_e      r_state;
  state_e      w_state_d;
  logic        r_owner_mem;   // 1: MEM owns the bus, 0: IF owns it
  logic        r_drop;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;

  logic        w_mem_req;
  logic        w_busy;
  logic        w_sel_mem;
  logic        w_sel_if;
  logic        w_done;
  logic        w_timeout;
  logic        w_finish;
  logic        w_drop;
  logic [31:0] w_rdata;

  // Request decode, completion and abort conditions.
  always_comb begin
    w_mem_req = mem_read_i | mem_write_i;
    w_busy    = (r_state != StIdle);
    w_sel_mem = (r_state == StIdle) & w_mem_req;
    w_sel_if  = (r_state == StIdle) & ~w_mem_req & if_req_i & ~if_kill_i;
    w_done    = (r_state == StData) & bus_rvalid_i;
    // A real response arriving in the limit cycle takes precedence over the abort.
    w_timeout = w_busy & TimeoutEn & (r_cnt >= TimeoutCnt) & ~w_done;
    w_finish  = w_done | w_timeout;
    // A kill in the completion cycle itself also suppresses the stale fetch data.
    w_drop    = r_drop | (~r_owner_mem & if_kill_i);
    w_rdata   = w_done ? bus_rdata_i : 32'h0;
  end

  // Next-state logic and all port outputs.
  always_comb begin
    w_state_d     = r_state;
    if_gnt_o      = 1'b0;
    if_rvalid_o   = 1'b0;
    if_rdata_o    = 32'h0;
    mem_rvalid_o  = 1'b0;
    mem_rdata_o   = 32'h0;
    bus_req_o     = 1'b0;
    bus_timeout_o = w_timeout;
    stall_mem_o   = w_mem_req & ~(r_owner_mem & w_finish);
    bus_we_o      = r_we;
    bus_addr_o    = r_addr;
    bus_wdata_o   = r_wdata;
    bus_be_o      = r_be;

    unique case (r_state)
      StIdle: begin
        if_gnt_o = w_sel_if;
        if (w_sel_mem || w_sel_if) begin
          w_state_d = StAddr;
        end
      end
      StAddr: begin
        bus_req_o = 1'b1;
        if (w_timeout) begin
          w_state_d = StIdle;
        end else if (bus_gnt_i) begin
          w_state_d = StData;
        end
      end
      StData: begin
        if (w_finish) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_finish) begin
      if (r_owner_mem) begin
        mem_rvalid_o = 1'b1;
        mem_rdata_o  = w_rdata;
      end else if (!w_drop) begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = w_rdata;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Latch the selected request; it stays on the bus pins until the next selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_mem <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_be        <= 4'h0;
    end else if (w_sel_mem) begin
      r_owner_mem <= 1'b1;
      r_we        <= mem_write_i;
      r_addr      <= mem_addr_i;
      r_wdata     <= mem_wdata_i;
      r_be        <= mem_be_i;
    end else if (w_sel_if) begin
      r_owner_mem <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= if_addr_i;
      r_wdata     <= 32'h0;
      r_be        <= 4'hF;
    end
  end

  // Remember a redirect that hit an in-flight fetch until the bus transaction ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= 1'b0;
    end else if (w_state_d == StIdle) begin
      r_drop <= 1'b0;
    end else if (w_busy && !r_owner_mem && if_kill_i) begin
      r_drop <= 1'b1;
    end
  end

  // Cycles spent in ADDR+DATA, including the current one; saturates at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'h0;
    end else if (w_state_d == StIdle) begin
      r_cnt <= 8'h0;
    end else if (!w_busy) begin
      r_cnt <= 8'h1;
    end else if (r_cnt != 8'hFF) begin
      r_cnt <= r_cnt + 8'h1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: load, contention, kill, timeout and reset mid-transaction.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_kill_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_be_i;
  logic        mem_rvalid_o;
  logic [31:0] mem_rdata_o;
  logic        stall_mem_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_kill_i    (if_kill_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .mem_addr_i   (mem_addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .mem_be_i     (mem_be_i),
    .mem_rvalid_o (mem_rvalid_o),
    .mem_rdata_o  (mem_rdata_o),
    .stall_mem_o  (stall_mem_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_be_o     (bus_be_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i),
    .bus_timeout_o(bus_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are changed here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes, still well before the next edge.
  task automatic settle();
    #2;
  endtask

  initial begin
    rst_n        = 1'b0;
    if_req_i     = 1'b0;
    if_addr_i    = 32'h0;
    if_kill_i    = 1'b0;
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    mem_addr_i   = 32'h0;
    mem_wdata_i  = 32'h0;
    mem_be_i     = 4'h0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = 32'h0;

    // Reset state
    #2;
    chk("rst_bus_req", 32'(bus_req_o), 32'h0);
    chk("rst_bus_addr", bus_addr_o, 32'h0);
    chk("rst_bus_be", 32'(bus_be_o), 32'h0);
    chk("rst_stall", 32'(stall_mem_o), 32'h0);
    chk("rst_if_gnt", 32'(if_gnt_o), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Load 0x100 -> 0xDEADBEEF, minimum latency
    mem_read_i = 1'b1;
    mem_addr_i = 32'h100;
    mem_be_i   = 4'hF;
    settle();
    chk("ld_idle_stall", 32'(stall_mem_o), 32'h1);
    chk("ld_idle_req", 32'(bus_req_o), 32'h0);
    tick();
    bus_gnt_i = 1'b1;
    settle();
    chk("ld_addr_req", 32'(bus_req_o), 32'h1);
    chk("ld_addr_addr", bus_addr_o, 32'h100);
    chk("ld_addr_we", 32'(bus_we_o), 32'h0);
    chk("ld_addr_stall", 32'(stall_mem_o), 32'h1);
    tick();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hDEADBEEF;
    settle();
    chk("ld_rvalid", 32'(mem_rvalid_o), 32'h1);
    chk("ld_rdata", mem_rdata_o, 32'hDEADBEEF);
    chk("ld_stall_released", 32'(stall_mem_o), 32'h0);
    chk("ld_data_req", 32'(bus_req_o), 32'h0);
    chk("ld_if_rvalid", 32'(if_rvalid_o), 32'h0);
    tick();
    mem_read_i   = 1'b0;
    bus_rvalid_i = 1'b0;
    settle();
    chk("ld_after_rvalid", 32'(mem_rvalid_o), 32'h0);
    chk("ld_after_req", 32'(bus_req_o), 32'h0);
    tick();

    // Contention: MEM write and IF fetch in the same IDLE cycle
    if_req_i    = 1'b1;
    if_addr_i   = 32'h40;
    mem_write_i = 1'b1;
    mem_addr_i  = 32'h200;
    mem_wdata_i = 32'h12345678;
    mem_be_i    = 4'h3;
    settle();
    chk("ct_idle_if_gnt", 32'(if_gnt_o), 32'h0);
    chk("ct_idle_stall", 32'(stall_mem_o), 32'h1);
    tick();
    bus_gnt_i = 1'b1;
    settle();
    chk("ct_addr_req", 32'(bus_req_o), 32'h1);
    chk("ct_addr_we", 32'(bus_we_o), 32'h1);
    chk("ct_addr_addr", bus_addr_o, 32'h200);
    chk("ct_addr_wdata", bus_wdata_o, 32'h12345678);
    chk("ct_addr_be", 32'(bus_be_o), 32'h3);
    chk("ct_addr_if_gnt", 32'(if_gnt_o), 32'h0);
    tick();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    settle();
    chk("ct_data_if_gnt", 32'(if_gnt_o), 32'h0);
    chk("ct_mem_rvalid", 32'(mem_rvalid_o), 32'h1);
    chk("ct_stall_released", 32'(stall_mem_o), 32'h0);
    chk("ct_if_rvalid", 32'(if_rvalid_o), 32'h0);
    tick();
    mem_write_i  = 1'b0;
    bus_rvalid_i = 1'b0;
    settle();
    chk("ct_idle2_if_gnt", 32'(if_gnt_o), 32'h1);
    tick();
    if_req_i  = 1'b0;
    bus_gnt_i = 1'b1;
    settle();
    chk("ct_if_req", 32'(bus_req_o), 32'h1);
    chk("ct_if_we", 32'(bus_we_o), 32'h0);
    chk("ct_if_be", 32'(bus_be_o), 32'hF);
    chk("ct_if_addr", bus_addr_o, 32'h40);
    chk("ct_if_wdata", bus_wdata_o, 32'h0);
    chk("ct_if_gnt_once", 32'(if_gnt_o), 32'h0);
    tick();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hCAFEF00D;
    settle();
    chk("ct_if_rvalid2", 32'(if_rvalid_o), 32'h1);
    chk("ct_if_rdata", if_rdata_o, 32'hCAFEF00D);
    chk("ct_if_mem_rvalid", 32'(mem_rvalid_o), 32'h0);
    tick();
    bus_rvalid_i = 1'b0;
    tick();

    // Kill: fetch 0x40 granted, redirect during DATA
    if_req_i  = 1'b1;
    if_addr_i = 32'h40;
    settle();
    chk("kl_if_gnt", 32'(if_gnt_o), 32'h1);
    tick();
    if_req_i  = 1'b0;
    bus_gnt_i = 1'b1;
    settle();
    chk("kl_addr_req", 32'(bus_req_o), 32'h1);
    tick();
    bus_gnt_i = 1'b0;
    if_kill_i = 1'b1;
    settle();
    chk("kl_data_if_rvalid", 32'(if_rvalid_o), 32'h0);
    tick();
    if_kill_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h11111111;
    settle();
    chk("kl_dropped_rvalid", 32'(if_rvalid_o), 32'h0);
    chk("kl_dropped_rdata", if_rdata_o, 32'h0);
    tick();
    bus_rvalid_i = 1'b0;
    if_req_i     = 1'b1;
    if_addr_i    = 32'h80;
    settle();
    chk("kl_back_idle_gnt", 32'(if_gnt_o), 32'h1);
    tick();
    if_req_i  = 1'b0;
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h22222222;
    settle();
    chk("kl_flag_cleared", 32'(if_rvalid_o), 32'h1);
    tick();
    bus_rvalid_i = 1'b0;
    tick();

    // Timeout: no grant ever, limit of 8 cycles
    mem_read_i = 1'b1;
    mem_addr_i = 32'h300;
    mem_be_i   = 4'hF;
    tick();
    for (int i = 1; i < 8; i++) begin
      settle();
      chk($sformatf("to_wait%0d_timeout", i), 32'(bus_timeout_o), 32'h0);
      chk($sformatf("to_wait%0d_stall", i), 32'(stall_mem_o), 32'h1);
      tick();
    end
    settle();
    chk("to_pulse", 32'(bus_timeout_o), 32'h1);
    chk("to_mem_rvalid", 32'(mem_rvalid_o), 32'h1);
    chk("to_mem_rdata", mem_rdata_o, 32'h0);
    chk("to_stall_released", 32'(stall_mem_o), 32'h0);
    tick();
    mem_read_i = 1'b0;
    settle();
    chk("to_pulse_end", 32'(bus_timeout_o), 32'h0);
    chk("to_idle_req", 32'(bus_req_o), 32'h0);
    tick();

    // Reset in the middle of a MEM read's DATA phase
    mem_read_i = 1'b1;
    mem_addr_i = 32'h400;
    tick();
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    settle();
    chk("rd_data_stall", 32'(stall_mem_o), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rd_rst_req", 32'(bus_req_o), 32'h0);
    chk("rd_rst_addr", bus_addr_o, 32'h0);
    chk("rd_rst_stall_hi", 32'(stall_mem_o), 32'h1);
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hBADBAD00;
    #1;
    chk("rd_rst_no_rvalid", 32'(mem_rvalid_o), 32'h0);
    mem_read_i = 1'b0;
    #1;
    chk("rd_rst_stall_lo", 32'(stall_mem_o), 32'h0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("rd_late_rvalid", 32'(mem_rvalid_o), 32'h0);
    chk("rd_late_req", 32'(bus_req_o), 32'h0);
    tick();
    settle();
    chk("rd_late_rvalid2", 32'(mem_rvalid_o), 32'h0);
    chk("rd_late_req2", 32'(bus_req_o), 32'h0);
    bus_rvalid_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
